// File: rtl/qos_pkg.sv
// Shared types and field helpers for the QoS traffic generator.
// Header fields sit in the MSBs: VC first, then destination.
package qos_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GEN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [1:0] MODE_CNT  = 2'd0;
    localparam logic [1:0] MODE_LFSR = 2'd1;
    localparam logic [1:0] MODE_RR   = 2'd2;
    localparam logic [1:0] MODE_RSV  = 2'd3;

    function automatic int unsigned vc_of(
        logic [31:0] w,
        int          bw,
        int          vcb
    );
        return (w >> (bw - vcb)) & ((32'd1 << vcb) - 32'd1);
    endfunction

    function automatic int unsigned dest_of(
        logic [31:0] w,
        int          bw,
        int          vcb,
        int          db
    );
        return (w >> (bw - vcb - db)) & ((32'd1 << db) - 32'd1);
    endfunction

    // Galois masks (right-shifting form) for maximal-length sequences
    function automatic logic [15:0] lfsr_taps(int w);
        case (w)
            2:       return 16'h0003;
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/generador_trafico_if.sv
// Push-side bus toward the Main FIFO.
// The generator drives wr/data_out; the FIFO returns full.
interface generador_trafico_if #(
    parameter int BW = 6
);
    logic          wr;
    logic [BW-1:0] data_out;
    logic          full;

    modport master (
        output wr,
        output data_out,
        input  full
    );

    modport slave (
        input  wr,
        input  data_out,
        output full
    );
endinterface

// File: rtl/generador_trafico_lfsr.sv
// Galois LFSR payload source, widths 2..16.
// nxt is the value the register takes on the next step.
module lfsr_payload
    import qos_pkg::*;
#(
    parameter int W    = 4,
    parameter int SEED = 1
) (
    input  logic         clk,
    input  logic         reset_L,
    input  logic         load,
    input  logic         step,
    output logic [W-1:0] nxt
);

    localparam logic [15:0] TAPS = lfsr_taps(W);

    logic [W-1:0] q_q;

    assign nxt = q_q[0] ? ((q_q >> 1) ^ TAPS[W-1:0])
                        : (q_q >> 1);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            q_q <= W'(SEED);
        end else if (load) begin
            q_q <= W'(SEED);
        end else if (step) begin
            q_q <= nxt;
        end
    end

endmodule

// File: rtl/generador_trafico.sv
// Burst traffic generator into the Main FIFO plus a
// per-destination drain checker for the destination FIFOs.
module generador_trafico
    import qos_pkg::*;
#(
    parameter int BW      = 6,
    parameter int VC_BITS = 1,
    parameter int D_BITS  = 1,
    parameter int ND      = 2,
    parameter int CW      = 16,
    parameter int SEED    = 1
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [7:0]           burst_len,
    input  logic [VC_BITS-1:0]   vc_sel,
    input  logic [D_BITS-1:0]    dest_sel,
    generador_trafico_if.master  mf,
    output logic                 busy,
    output logic                 done,
    input  logic                 drain_en,
    input  logic [ND-1:0]        d_empty,
    output logic [ND-1:0]        d_rd,
    input  logic [ND*BW-1:0]     d_data,
    output logic [ND*CW-1:0]     rx_count,
    output logic                 err_dest
);

    localparam int PW = BW - VC_BITS - D_BITS;
    localparam int HW = VC_BITS + D_BITS;

    state_e        state_q;
    logic          start_q;
    logic          busy_q;
    logic          done_q;
    logic [7:0]    len_q;
    logic [7:0]    sent_q;
    logic [7:0]    sent_d;
    logic [1:0]    mode_q;
    logic [HW-1:0] hdr_q;
    logic [HW-1:0] hdr_d;
    logic [HW-1:0] hdr0_d;
    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;
    logic [PW-1:0] pay_d;
    logic [PW-1:0] pay0_d;
    logic [PW-1:0] lfsr_nxt;
    logic [BW-1:0] dout_q;
    logic          launch;
    logic          acc;

    // Next round-robin header, skipping destinations with no FIFO
    function automatic logic [HW-1:0] rr_next(logic [HW-1:0] h);
        logic [HW-1:0] n;
        n = h + 1'b1;
        for (int k = 0; k < (1 << D_BITS); k++) begin
            if (int'(n[D_BITS-1:0]) >= ND) n = n + 1'b1;
        end
        return n;
    endfunction

    assign launch      = (state_q == S_IDLE) & start & ~start_q;
    assign acc         = busy_q & ~mf.full;
    assign mf.wr       = acc;
    assign mf.data_out = dout_q;
    assign busy        = busy_q;
    assign done        = done_q;

    always_comb begin
        sent_d = sent_q + 8'd1;
        cnt_d  = (cnt_q == {PW{1'b1}}) ? PW'(1) : cnt_q + 1'b1;
        hdr_d  = hdr_q;
        if (mode_q == MODE_RR) hdr_d = rr_next(hdr_q);
        pay_d  = (mode_q == MODE_LFSR) ? lfsr_nxt : cnt_d;
        hdr0_d = (mode == MODE_RR) ? '0 : {vc_sel, dest_sel};
        pay0_d = (mode == MODE_LFSR) ? PW'(SEED) : PW'(1);
    end

    lfsr_payload #(
        .W    (PW),
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_L (reset_L),
        .load    (launch),
        .step    (acc & (mode_q == MODE_LFSR)),
        .nxt     (lfsr_nxt)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            len_q   <= '0;
            sent_q  <= '0;
            mode_q  <= MODE_CNT;
            hdr_q   <= '0;
            cnt_q   <= PW'(1);
            dout_q  <= '0;
        end else begin
            start_q <= start;
            unique case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        len_q  <= burst_len;
                        sent_q <= '0;
                        mode_q <= mode;
                        hdr_q  <= hdr0_d;
                        cnt_q  <= PW'(1);
                        dout_q <= {hdr0_d, pay0_d};
                        if (burst_len == 8'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_GEN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_GEN: begin
                    if (acc) begin
                        sent_q <= sent_d;
                        cnt_q  <= cnt_d;
                        hdr_q  <= hdr_d;
                        dout_q <= {hdr_d, pay_d};
                        if (sent_d == len_q) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    logic [ND-1:0] rd_q;
    logic [ND-1:0] hit;
    logic          err_q;

    assign d_rd     = {ND{drain_en & reset_L}} & ~d_empty;
    assign err_dest = err_q;

    // Read data lands one cycle after the pop, hence rd_q
    for (genvar i = 0; i < ND; i++) begin : g_rx
        logic [CW-1:0] rx_q;

        assign hit[i] = rd_q[i] &
            (dest_of(32'(d_data[i*BW +: BW]), BW, VC_BITS, D_BITS)
             != 32'(i));
        assign rx_count[i*CW +: CW] = rx_q;

        always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
                rx_q <= '0;
            end else if (rd_q[i] && (rx_q != {CW{1'b1}})) begin
                rx_q <= rx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            rd_q <= d_rd;
            if (|hit) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_generador_trafico.sv
// Directed + randomized bench for generador_trafico with a
// word-level reference model and modelled destination FIFOs.
module tb_generador_trafico;

    localparam int BW = 6;
    localparam int VB = 1;
    localparam int DB = 1;
    localparam int ND = 2;
    localparam int CW = 16;
    localparam int PW = BW - VB - DB;
    localparam int HW = VB + DB;

    logic              clk = 1'b0;
    logic              reset_L = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [7:0]        burst_len = 8'd0;
    logic [VB-1:0]     vc_sel = '0;
    logic [DB-1:0]     dest_sel = '0;
    logic              busy;
    logic              done;
    logic              drain_en = 1'b0;
    logic [ND-1:0]     d_empty = '1;
    logic [ND-1:0]     d_rd;
    logic [ND*BW-1:0]  d_data = '0;
    logic [ND*CW-1:0]  rx_count;
    logic              err_dest;

    generador_trafico_if #(.BW(BW)) mf();

    generador_trafico #(
        .BW(BW), .VC_BITS(VB), .D_BITS(DB),
        .ND(ND), .CW(CW), .SEED(1)
    ) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .start     (start),
        .mode      (mode),
        .burst_len (burst_len),
        .vc_sel    (vc_sel),
        .dest_sel  (dest_sel),
        .mf        (mf),
        .busy      (busy),
        .done      (done),
        .drain_en  (drain_en),
        .d_empty   (d_empty),
        .d_rd      (d_rd),
        .d_data    (d_data),
        .rx_count  (rx_count),
        .err_dest  (err_dest)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [BW-1:0] fq [ND][$];
    int            exp_rx [ND];
    logic [BW-1:0] got [$];
    logic [BW-1:0] ref_seq [$];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Word k of a burst, straight from the payload/header rules
    function automatic logic [BW-1:0] model_word(
        int md, int k, logic [VB-1:0] vc, logic [DB-1:0] ds
    );
        int pay;
        int hdr;
        int hl[$];
        pay = (k % ((1 << PW) - 1)) + 1;
        if (md == 2) begin
            for (int h = 0; h < (1 << HW); h++)
                if ((h % (1 << DB)) < ND) hl.push_back(h);
            hdr = hl[k % hl.size()];
        end else begin
            hdr = int'({vc, ds});
        end
        return BW'((hdr << PW) | pay);
    endfunction

    task automatic burst(
        input int md, input int len,
        input logic [VB-1:0] vc, input logic [DB-1:0] ds,
        input int pfull, input int fmask,
        input bit rstart, input bit cw
    );
        int k;
        int cyc;
        logic f;
        k = 0;
        cyc = 0;
        got.delete();
        @(negedge clk);
        mode = md[1:0];
        burst_len = len[7:0];
        vc_sel = vc;
        dest_sel = ds;
        mf.full = 1'b0;
        start = 1'b1;
        @(negedge clk);
        if (len == 0) begin
            chk("zlen_done", done, 1);
            chk("zlen_busy", busy, 0);
        end else begin
            chk("launch_busy", busy, 1);
            while (k < len && cyc < 400) begin
                f = (cyc < 32) ? fmask[cyc] : 1'b0;
                if ($urandom_range(99) < pfull) f = 1'b1;
                mf.full = f;
                if (rstart) start = 1'($urandom_range(1));
                #1;
                chk("wr", mf.wr, !f);
                if (cw)
                    chk("data_out", mf.data_out,
                        model_word(md, k, vc, ds));
                if (mf.wr) begin
                    got.push_back(mf.data_out);
                    k++;
                end
                cyc++;
                @(negedge clk);
            end
            chk("pushes", k, len);
            if (pfull == 0)
                chk("cycles", cyc, len + $countones(fmask));
            mf.full = 1'b0;
            #1;
            chk("end_done", done, 1);
            chk("end_busy", busy, 0);
            chk("end_wr", mf.wr, 0);
        end
        start = 1'b0;
        @(negedge clk);
        chk("idle_done", done, 0);
    endtask

    task automatic to_fifos();
        foreach (got[j]) fq[int'(got[j][PW +: DB])].push_back(got[j]);
    endtask

    task automatic drain(input int pen);
        int idle;
        int guard;
        logic [ND-1:0] e;
        idle = 0;
        guard = 0;
        while (idle < 3 && guard < 1000) begin
            @(negedge clk);
            drain_en = ($urandom_range(99) < pen);
            for (int i = 0; i < ND; i++)
                d_empty[i] = (fq[i].size() == 0);
            e = {ND{drain_en}} & ~d_empty;
            #1;
            chk("d_rd", d_rd, e);
            @(posedge clk);
            #1;
            for (int i = 0; i < ND; i++) begin
                if (e[i]) begin
                    d_data[i*BW +: BW] = fq[i].pop_front();
                    exp_rx[i]++;
                end
            end
            if (fq[0].size() == 0 && fq[1].size() == 0) idle++;
            else idle = 0;
            guard++;
        end
        chk("drain_guard", guard < 1000, 1);
        drain_en = 1'b0;
        d_empty = '1;
    endtask

    task automatic chk_rx();
        for (int i = 0; i < ND; i++)
            chk("rx_count", rx_count[i*CW +: CW], exp_rx[i]);
    endtask

    initial begin
        mf.full = 1'b0;
        exp_rx[0] = 0;
        exp_rx[1] = 0;

        // reset state, with drain requests pending
        drain_en = 1'b1;
        d_empty = '0;
        repeat (2) @(negedge clk);
        chk("rst_wr", mf.wr, 0);
        chk("rst_data", mf.data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_d_rd", d_rd, 0);
        chk("rst_rx", rx_count, 0);
        chk("rst_err", err_dest, 0);
        drain_en = 1'b0;
        d_empty = '1;
        reset_L = 1'b1;

        // fixed header, no backpressure
        burst(0, 4, 1'b0, 1'b1, 0, 0, 0, 1);
        chk("w0", got[0], 6'b01_0001);
        chk("w3", got[3], 6'b01_0100);

        // three stall cycles after the second push
        burst(0, 4, 1'b0, 1'b1, 0, 'b11100, 0, 1);

        // round-robin headers then drain
        burst(2, 8, 1'b0, 1'b0, 0, 0, 0, 1);
        to_fifos();
        drain(100);
        chk("rr_rx0", rx_count[0 +: CW], 4);
        chk("rr_rx1", rx_count[CW +: CW], 4);
        chk("rr_err", err_dest, 0);

        // LFSR payload: 15 distinct non-zero, repeatable
        burst(1, 15, 1'b1, 1'b0, 0, 0, 0, 0);
        ref_seq = got;
        for (int a = 0; a < 15; a++) begin
            chk("lfsr_nz", got[a][PW-1:0] != 0, 1);
            chk("lfsr_hdr", got[a][BW-1:PW], 2'b10);
            for (int b = a + 1; b < 15; b++)
                chk("lfsr_uniq", got[a] != got[b], 1);
        end
        burst(1, 15, 1'b1, 1'b0, 20, 0, 0, 0);
        for (int a = 0; a < 15; a++)
            chk("lfsr_rep", got[a], ref_seq[a]);

        // zero-length burst
        burst(0, 0, 1'b0, 1'b0, 0, 0, 0, 1);

        // randomized bursts with backpressure and start noise
        repeat (6) begin
            int md;
            case ($urandom_range(2))
                0: md = 0;
                1: md = 2;
                default: md = 3;
            endcase
            burst(md, $urandom_range(20, 1),
                  1'($urandom_range(1)), 1'($urandom_range(1)),
                  40, 0, 1, 1);
            to_fifos();
            drain(60);
            chk_rx();
            chk("rnd_err", err_dest, 0);
        end

        // misrouted word in FIFO 1
        fq[1].push_back(6'b00_0101);
        drain(100);
        chk_rx();
        chk("err_set", err_dest, 1);
        repeat (3) @(negedge clk);
        chk("err_sticky", err_dest, 1);

        // reset mid-burst
        @(negedge clk);
        mode = 2'd0;
        burst_len = 8'd10;
        start = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_busy", busy, 1);
        drain_en = 1'b1;
        d_empty = '0;
        reset_L = 1'b0;
        #1;
        chk("mr_wr", mf.wr, 0);
        chk("mr_data", mf.data_out, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_d_rd", d_rd, 0);
        chk("mr_rx", rx_count, 0);
        chk("mr_err", err_dest, 0);
        start = 1'b0;
        drain_en = 1'b0;
        d_empty = '1;
        exp_rx[0] = 0;
        exp_rx[1] = 0;
        @(negedge clk);
        reset_L = 1'b1;
        burst(0, 3, 1'b1, 1'b0, 0, 0, 0, 1);
        chk("restart_w0", got[0], 6'b10_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
